banco_registro_param: RTL and testbench
=======================================

BANCO_REGISTRO_PARAM -- requirements
Module: banco_registro_param

Interface
REQ-001 The block SHALL have parameter BITS_PALAVRA, default 32, data word width.
REQ-002 The block SHALL have parameter END_REGISTROS, default 4, address width; register count is 2^END_REGISTROS.
REQ-003 The block SHALL have parameter ZERO_R0, default 0; when 1, register 0 reads 0 and ignores writes.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its falling edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low; clears all state.
REQ-006 The block SHALL have port habilita, input, 1 bit: write enable.
REQ-007 The block SHALL have port end_escrita, input, END_REGISTROS bits: write address.
REQ-008 The block SHALL have port E, input, BITS_PALAVRA bits: write data.
REQ-009 The block SHALL have ports end_a and end_b, input, END_REGISTROS bits each: read addresses for A and B.
REQ-010 The block SHALL have ports A and B, output, BITS_PALAVRA bits each: registered read data.
REQ-011 The block SHALL have port limpa, input, 1 bit: request a sequential clear of all registers.
REQ-012 The block SHALL have port ocupado, output, 1 bit: high while the clear sequence runs.
REQ-013 The block SHALL have port escrita_perdida, output, 1 bit: one-edge pulse flagging a discarded write.

Function
REQ-014 FSM states SHALL be OCIOSO and LIMPANDO; reset enters OCIOSO.
REQ-015 In OCIOSO with habilita=1 and limpa=0, registro[end_escrita] SHALL take E at the falling edge.
REQ-016 In OCIOSO, A SHALL load registro[end_a] and B SHALL load registro[end_b] at every falling edge; read latency is one edge.
REQ-017 Bypass: when a write occurs at an edge and end_escrita equals end_a (or end_b), A (or B) SHALL load E rather than the old content.
REQ-018 With ZERO_R0=1, writes to address 0 SHALL be dropped without asserting escrita_perdida, reads of address 0 SHALL return 0, and bypass SHALL not apply to address 0.
REQ-019 OCIOSO with limpa=1 SHALL move to LIMPANDO at that edge; the internal counter cont SHALL be set to 0 and ocupado SHALL go to 1.
REQ-020 Any habilita=1 coinciding with the OCIOSO->LIMPANDO transition SHALL be discarded; limpa has priority.
REQ-021 In LIMPANDO, each falling edge SHALL write 0 to registro[cont] and increment cont.
REQ-022 After zeroing register 2^END_REGISTROS-1, the FSM SHALL return to OCIOSO and ocupado SHALL drop to 0 at that same edge; cont SHALL wrap to 0.
REQ-023 The clear SHALL take exactly 2^END_REGISTROS falling edges after the starting edge.
REQ-024 In LIMPANDO, A and B SHALL hold their values, limpa SHALL be ignored, and habilita=1 SHALL be discarded.
REQ-025 escrita_perdida SHALL be 1 for one edge period following any edge at which a habilita=1 write was discarded (REQ-020, REQ-024), and 0 otherwise.
REQ-026 Writes and reads to distinct addresses in the same edge SHALL both take effect, with no ordering dependence.

Reset
REQ-027 While reset=0, all registers, A, B, cont, ocupado, and escrita_perdida SHALL be 0 immediately, independent of clock, and the FSM SHALL be in OCIOSO.
REQ-028 A reset asserted mid-clear SHALL abort the sequence; the first falling edge after release SHALL operate in OCIOSO.

Verification
REQ-029 Write/read: write 0xDEADBEEF to r5, then set end_a=5 -> A=0xDEADBEEF after the next falling edge.
REQ-030 Bypass: habilita=1, end_escrita=3, E=0x12345678, end_a=end_b=3 in one edge -> A=B=0x12345678 after that edge.
REQ-031 Clear: fill r0..r15 with nonzero values, pulse limpa -> ocupado=1 for 16 edges; then all reads return 0 and ocupado=0.
REQ-032 Discard: habilita=1 to r7 with E=0xAAAA5555 during LIMPANDO -> escrita_perdida pulses once; r7 reads 0 after the clear.
REQ-033 Reset mid-clear: assert reset=0 at cont=6, release -> ocupado=0, A=B=0, all registers read 0, and a normal write then succeeds.
REQ-034 ZERO_R0=1: write 0xFFFFFFFF to r0 -> A=0 with end_a=0 and escrita_perdida=0.

Source files
------------

// File: rtl/banco_registro_param_if.sv
// Bus bundle for banco_registro_param: write port, two read ports and the clear handshake.
interface banco_registro_param_if #(
  parameter int unsigned BITS_PALAVRA  = 32,
  parameter int unsigned END_REGISTROS = 4
);
  logic                     habilita;
  logic [END_REGISTROS-1:0] end_escrita;
  logic [BITS_PALAVRA-1:0]  E;
  logic [END_REGISTROS-1:0] end_a;
  logic [END_REGISTROS-1:0] end_b;
  logic [BITS_PALAVRA-1:0]  A;
  logic [BITS_PALAVRA-1:0]  B;
  logic                     limpa;
  logic                     ocupado;
  logic                     escrita_perdida;

  modport master (
    output habilita, end_escrita, E, end_a, end_b, limpa,
    input  A, B, ocupado, escrita_perdida
  );

  modport slave (
    input  habilita, end_escrita, E, end_a, end_b, limpa,
    output A, B, ocupado, escrita_perdida
  );
endinterface

// File: rtl/banco_registro_param.sv
// Parameterised register file, falling-edge clocked, with write-through bypass
// and a sequential clear that walks every register once.
module banco_registro_param #(
  parameter int unsigned BITS_PALAVRA  = 32,
  parameter int unsigned END_REGISTROS = 4,
  parameter bit          ZERO_R0       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  banco_registro_param_if.slave bus
);
  localparam int unsigned NUM_REGS = 2 ** END_REGISTROS;
  localparam logic [END_REGISTROS-1:0] ULTIMO = END_REGISTROS'(NUM_REGS - 1);

  typedef enum logic {OCIOSO = 1'b0, LIMPANDO = 1'b1} estado_t;

  estado_t                  state, state_n;
  logic [END_REGISTROS-1:0] cont, cont_n;
  logic [BITS_PALAVRA-1:0]  a_q, a_n, b_q, b_n;
  logic                     ocupado_q, ocupado_n;
  logic                     perdida_q, perdida_n;
  logic                     we;
  logic [END_REGISTROS-1:0] waddr;
  logic [BITS_PALAVRA-1:0]  wdata;
  logic [BITS_PALAVRA-1:0]  rd_a, rd_b;
  logic                     escrita_ok;

  logic [BITS_PALAVRA-1:0]  registro [NUM_REGS];

  // Register 0 is hardwired to zero when ZERO_R0 is set.
  assign rd_a = (ZERO_R0 && bus.end_a == '0) ? '0 : registro[bus.end_a];
  assign rd_b = (ZERO_R0 && bus.end_b == '0) ? '0 : registro[bus.end_b];
  assign escrita_ok = bus.habilita && !(ZERO_R0 && bus.end_escrita == '0);

  // Next-state, write port selection and output next values.
  always_comb begin
    state_n   = state;
    cont_n    = cont;
    a_n       = a_q;
    b_n       = b_q;
    ocupado_n = ocupado_q;
    perdida_n = 1'b0;
    we        = 1'b0;
    waddr     = bus.end_escrita;
    wdata     = bus.E;
    case (state)
      OCIOSO: begin
        a_n = rd_a;
        b_n = rd_b;
        if (bus.limpa) begin
          // Clear request wins over a coincident write.
          state_n   = LIMPANDO;
          cont_n    = '0;
          ocupado_n = 1'b1;
          perdida_n = bus.habilita;
        end else if (escrita_ok) begin
          we = 1'b1;
          if (bus.end_a == bus.end_escrita) a_n = bus.E;
          if (bus.end_b == bus.end_escrita) b_n = bus.E;
        end
      end
      LIMPANDO: begin
        we        = 1'b1;
        waddr     = cont;
        wdata     = '0;
        cont_n    = cont + END_REGISTROS'(1);
        perdida_n = bus.habilita;
        if (cont == ULTIMO) begin
          state_n   = OCIOSO;
          ocupado_n = 1'b0;
        end
      end
      default: state_n = OCIOSO;
    endcase
  end

  // Control and output registers.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state     <= OCIOSO;
      cont      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ocupado_q <= 1'b0;
      perdida_q <= 1'b0;
    end else begin
      state     <= state_n;
      cont      <= cont_n;
      a_q       <= a_n;
      b_q       <= b_n;
      ocupado_q <= ocupado_n;
      perdida_q <= perdida_n;
    end
  end

  // Storage array.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) registro[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (we && waddr == END_REGISTROS'(i)) registro[i] <= wdata;
      end
    end
  end

  assign bus.A               = a_q;
  assign bus.B               = b_q;
  assign bus.ocupado         = ocupado_q;
  assign bus.escrita_perdida = perdida_q;
endmodule

// File: tb/tb_banco_registro_param.sv
// Directed self-checking bench for banco_registro_param (default and ZERO_R0 variants).
module tb_banco_registro_param;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  banco_registro_param_if #(.BITS_PALAVRA(32), .END_REGISTROS(4)) bus ();
  banco_registro_param_if #(.BITS_PALAVRA(32), .END_REGISTROS(4)) bus_z ();

  banco_registro_param #(.BITS_PALAVRA(32), .END_REGISTROS(4), .ZERO_R0(1'b0)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );
  banco_registro_param #(.BITS_PALAVRA(32), .END_REGISTROS(4), .ZERO_R0(1'b1)) dut_z (
    .clock(clock), .reset(reset), .bus(bus_z.slave)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One active (falling) edge; returns at the following rising edge.
  task automatic step();
    @(negedge clock);
    @(posedge clock);
  endtask

  function automatic logic [31:0] val_fill(input int i);
    return 32'h1000_0001 + 32'(i) * 32'h0000_0111;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.habilita = 1'b0; bus.end_escrita = '0; bus.E = '0;
    bus.end_a = '0; bus.end_b = '0; bus.limpa = 1'b0;
    bus_z.habilita = 1'b0; bus_z.end_escrita = '0; bus_z.E = '0;
    bus_z.end_a = '0; bus_z.end_b = '0; bus_z.limpa = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    chk("reset_A", bus.A, 32'h0);
    chk("reset_B", bus.B, 32'h0);
    chk("reset_ocupado", 32'(bus.ocupado), 32'h0);
    chk("reset_perdida", 32'(bus.escrita_perdida), 32'h0);
    @(posedge clock);
    reset = 1'b1;

    // Write then read back.
    bus.habilita = 1'b1; bus.end_escrita = 4'd5; bus.E = 32'hDEADBEEF;
    step();
    bus.habilita = 1'b0; bus.end_a = 4'd5; bus.end_b = 4'd0;
    step();
    chk("rd_r5_A", bus.A, 32'hDEADBEEF);
    chk("rd_r0_B", bus.B, 32'h0);

    // Bypass on both ports.
    bus.habilita = 1'b1; bus.end_escrita = 4'd3; bus.E = 32'h12345678;
    bus.end_a = 4'd3; bus.end_b = 4'd3;
    step();
    chk("bypass_A", bus.A, 32'h12345678);
    chk("bypass_B", bus.B, 32'h12345678);

    // Write and reads to distinct addresses in one edge.
    bus.end_escrita = 4'd6; bus.E = 32'h0BADCAFE; bus.end_a = 4'd5; bus.end_b = 4'd3;
    step();
    chk("distinct_A", bus.A, 32'hDEADBEEF);
    chk("distinct_B", bus.B, 32'h12345678);
    bus.habilita = 1'b0; bus.end_a = 4'd6;
    step();
    chk("rd_r6_A", bus.A, 32'h0BADCAFE);

    // Fill all registers with nonzero values.
    for (int i = 0; i < 16; i++) begin
      bus.habilita = 1'b1; bus.end_escrita = 4'(i); bus.E = val_fill(i);
      step();
    end
    bus.habilita = 1'b0; bus.end_a = 4'd15; bus.end_b = 4'd0;
    step();
    chk("fill_r15", bus.A, val_fill(15));
    chk("fill_r0", bus.B, val_fill(0));

    // Sequential clear with a discarded write mid-sequence.
    bus.limpa = 1'b1;
    step();
    bus.limpa = 1'b0;
    chk("clr_start_ocupado", 32'(bus.ocupado), 32'h1);
    chk("clr_start_perdida", 32'(bus.escrita_perdida), 32'h0);
    for (int e = 1; e <= 16; e++) begin
      if (e == 3) begin
        bus.habilita = 1'b1; bus.end_escrita = 4'd7; bus.E = 32'hAAAA5555; bus.end_a = 4'd7;
      end else begin
        bus.habilita = 1'b0;
      end
      step();
      chk($sformatf("clr_ocupado_e%0d", e), 32'(bus.ocupado), (e < 16) ? 32'h1 : 32'h0);
      if (e == 3) begin
        chk("discard_pulse", 32'(bus.escrita_perdida), 32'h1);
        chk("clr_A_hold", bus.A, val_fill(15));
      end
      if (e == 4) chk("discard_pulse_end", 32'(bus.escrita_perdida), 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      bus.end_a = 4'(i); bus.end_b = 4'(15 - i);
      step();
      chk($sformatf("post_clr_A_r%0d", i), bus.A, 32'h0);
      chk($sformatf("post_clr_B_r%0d", 15 - i), bus.B, 32'h0);
    end

    // Reset in the middle of a clear; the write coincident with limpa is discarded.
    bus.habilita = 1'b1; bus.end_escrita = 4'd9; bus.E = 32'h00009999;
    step();
    bus.end_escrita = 4'd2; bus.E = 32'h00000055; bus.limpa = 1'b1;
    bus.end_a = 4'd9; bus.end_b = 4'd9;
    step();
    bus.habilita = 1'b0; bus.limpa = 1'b0;
    chk("limpa_prio_perdida", 32'(bus.escrita_perdida), 32'h1);
    chk("limpa_start_A", bus.A, 32'h00009999);
    for (int k = 0; k < 6; k++) step();
    chk("mid_clr_ocupado", 32'(bus.ocupado), 32'h1);
    reset = 1'b0;
    #2;
    chk("rst_mid_ocupado", 32'(bus.ocupado), 32'h0);
    chk("rst_mid_A", bus.A, 32'h0);
    chk("rst_mid_B", bus.B, 32'h0);
    @(posedge clock);
    reset = 1'b1;
    bus.end_a = 4'd9; bus.end_b = 4'd2;
    step();
    chk("rst_r9", bus.A, 32'h0);
    chk("rst_r2", bus.B, 32'h0);
    chk("rst_ocupado_after", 32'(bus.ocupado), 32'h0);
    bus.habilita = 1'b1; bus.end_escrita = 4'd4; bus.E = 32'h00000044;
    step();
    bus.habilita = 1'b0; bus.end_a = 4'd4;
    step();
    chk("post_rst_write", bus.A, 32'h00000044);
    chk("post_rst_ocupado", 32'(bus.ocupado), 32'h0);

    // ZERO_R0 variant: r0 write dropped silently, no bypass for r0.
    bus_z.habilita = 1'b1; bus_z.end_escrita = 4'd0; bus_z.E = 32'hFFFFFFFF;
    bus_z.end_a = 4'd0; bus_z.end_b = 4'd0;
    step();
    chk("z_bypass_A", bus_z.A, 32'h0);
    chk("z_perdida", 32'(bus_z.escrita_perdida), 32'h0);
    bus_z.end_escrita = 4'd1; bus_z.E = 32'h0000CAFE;
    step();
    bus_z.habilita = 1'b0; bus_z.end_b = 4'd1;
    step();
    chk("z_r0_A", bus_z.A, 32'h0);
    chk("z_r1_B", bus_z.B, 32'h0000CAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
